// File: rtl/display_pkg.sv
// Shared types and frame geometry for the seven-segment display serializer.
package display_pkg;

    localparam int FRAME_BITS = 48;
    localparam int BYTE_BITS  = 8;
    localparam int DIGITS     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_e;

    function automatic logic [BYTE_BITS-1:0] pack_byte(input logic dp, input logic [6:0] seg);
        return {dp, seg};
    endfunction

endpackage

// File: rtl/display_serializer_tick_gen.sv
// Half-period tick generator: divides i_clk by CLK_DIV while active and enabled.
module serial_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_active,
    output logic o_tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_q;
    logic [7:0] div_d;

    // Divider restarts from zero every time the serializer leaves IDLE/LOAD,
    // so each SHIFT/LATCH phase lasts exactly CLK_DIV cycles.
    always_comb begin
        o_tick = i_en && i_active && (div_q == DIV_LAST);
        div_d  = div_q;
        if (!i_active) begin
            div_d = 8'd0;
        end else if (div_q == DIV_LAST) begin
            div_d = 8'd0;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_q <= 8'd0;
        end else if (i_en) begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/display_serializer.sv
// Serializes six seven-segment bytes into a shift-register chain, then latches.
// Optional decimal-point input i_dp is added when SERIAL_DP_EN is defined.
//   state | meaning
//   IDLE  | waiting for i_start
//   LOAD  | capture segment inputs into the frame register
//   SHIFT | clock out 48 bits, MSB first, low then high half-period each
//   LATCH | pulse o_serial_latch for one half-period
module display_serializer
    import display_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_start,
    input  logic [6:0] i_hours_msb,
    input  logic [6:0] i_hours_lsb,
    input  logic [6:0] i_minutes_msb,
    input  logic [6:0] i_minutes_lsb,
    input  logic [6:0] i_seconds_msb,
    input  logic [6:0] i_seconds_lsb,
`ifdef SERIAL_DP_EN
    input  logic [5:0] i_dp,
`endif
    output logic       o_serial_data,
    output logic       o_serial_clk,
    output logic       o_serial_latch,
    output logic       o_busy
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [5:0]              bit_q, bit_d;
    logic                    sclk_q, sclk_d;
    logic                    tick;
    logic [DIGITS-1:0]       dp_w;
    logic [FRAME_BITS-1:0]   frame_w;

`ifdef SERIAL_DP_EN
    assign dp_w = i_dp;
`else
    assign dp_w = '0;
`endif

    assign frame_w = {pack_byte(dp_w[5], i_hours_msb),
                      pack_byte(dp_w[4], i_hours_lsb),
                      pack_byte(dp_w[3], i_minutes_msb),
                      pack_byte(dp_w[2], i_minutes_lsb),
                      pack_byte(dp_w[1], i_seconds_msb),
                      pack_byte(dp_w[0], i_seconds_lsb)};

    serial_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_en     (i_en),
        .i_active ((state_q == SHIFT) || (state_q == LATCH)),
        .o_tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = LOAD;
            end
            LOAD: begin
                sr_d    = frame_w;
                bit_d   = 6'd0;
                sclk_d  = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: advance data while the receiver clock is low.
                        sclk_d = 1'b0;
                        sr_d   = {sr_q[FRAME_BITS-2:0], 1'b0};
                        if (bit_q == LAST_BIT) begin
                            bit_d   = 6'd0;
                            state_d = LATCH;
                        end else begin
                            bit_d = bit_q + 6'd1;
                        end
                    end
                end
            end
            LATCH: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= 6'd0;
            sclk_q  <= 1'b0;
        end else if (i_en) begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
        end
    end

    assign o_serial_data  = (state_q == SHIFT) && sr_q[FRAME_BITS-1];
    assign o_serial_clk   = sclk_q;
    assign o_serial_latch = (state_q == LATCH);
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_display_serializer.sv
// Directed bench for display_serializer (CLK_DIV=2 main instance, CLK_DIV=1 side instance).
module tb_display_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic [6:0] hm = '0, hl = '0, mm = '0, ml = '0, sm = '0, sl = '0;
`ifdef SERIAL_DP_EN
    logic [5:0] dp = '0;
`endif
    logic sdata, sclk, slatch, busy;
    logic sdata1, sclk1, slatch1, busy1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    display_serializer #(.CLK_DIV(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_start(start),
        .i_hours_msb(hm), .i_hours_lsb(hl), .i_minutes_msb(mm),
        .i_minutes_lsb(ml), .i_seconds_msb(sm), .i_seconds_lsb(sl),
`ifdef SERIAL_DP_EN
        .i_dp(dp),
`endif
        .o_serial_data(sdata), .o_serial_clk(sclk),
        .o_serial_latch(slatch), .o_busy(busy)
    );

    display_serializer #(.CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_start(start),
        .i_hours_msb(hm), .i_hours_lsb(hl), .i_minutes_msb(mm),
        .i_minutes_lsb(ml), .i_seconds_msb(sm), .i_seconds_lsb(sl),
`ifdef SERIAL_DP_EN
        .i_dp(dp),
`endif
        .o_serial_data(sdata1), .o_serial_clk(sclk1),
        .o_serial_latch(slatch1), .o_busy(busy1)
    );

    // Side monitor for the CLK_DIV=1 instance; restarts on each busy rise.
    int          busy1_cnt = 0;
    logic [47:0] word1 = '0;
    logic        pbusy1 = 1'b0, psclk1 = 1'b0;
    always @(negedge clk) begin
        if (busy1 && !pbusy1) begin
            busy1_cnt = 1;
            word1 = '0;
        end else if (busy1) begin
            busy1_cnt++;
        end
        if (sclk1 && !psclk1) word1 = {word1[46:0], sdata1};
        pbusy1 = busy1;
        psclk1 = sclk1;
    end

    task automatic set_segs(input logic [6:0] a, b, c, d, e, f);
        hm = a; hl = b; mm = c; ml = d; sm = e; sl = f;
    endtask

    task automatic run_frame(
        input  int restart_at, input int en_off_at, input int en_off_len, input int reset_at,
        output logic [47:0] word, output int busy_cyc, output int rises, output int rises_at_latch,
        output int latch_cyc, output int latch_pulses,
        output bit frozen_ok, output bit reset_zero, output bit timeout);
        int c;
        logic psclk, platch;
        logic [3:0] snap;
        word = '0; busy_cyc = 0; rises = 0; rises_at_latch = 0; latch_cyc = 0;
        latch_pulses = 0; frozen_ok = 1; reset_zero = 1; timeout = 1;
        c = 0; psclk = 0; platch = 0; snap = '0;
        @(negedge clk);
        start = 1'b1;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1) start = 1'b0;
            if (busy) busy_cyc++;
            if (sclk && !psclk) begin
                rises++;
                word = {word[46:0], sdata};
            end
            if (slatch) latch_cyc++;
            if (slatch && !platch) begin
                latch_pulses++;
                rises_at_latch = rises;
            end
            if (en_off_at > 0 && c > en_off_at && c <= en_off_at + en_off_len &&
                {sdata, sclk, slatch, busy} !== snap) frozen_ok = 0;
            psclk = sclk;
            platch = slatch;
            if (!busy) begin
                timeout = 0;
                break;
            end
            if (restart_at > 0 && c == restart_at) begin
                start = 1'b1;
                set_segs(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
            end else if (restart_at > 0 && c == restart_at + 1) begin
                start = 1'b0;
            end
            if (en_off_at > 0 && c == en_off_at) begin
                en = 1'b0;
                snap = {sdata, sclk, slatch, busy};
            end
            if (en_off_at > 0 && c == en_off_at + en_off_len) en = 1'b1;
            if (reset_at > 0 && c == reset_at) begin
                reset = 1'b1;
                #1;
                if ({sdata, sclk, slatch, busy} !== 4'b0000) reset_zero = 0;
                @(negedge clk);
                reset = 1'b0;
                timeout = 0;
                break;
            end
        end
    endtask

    logic [47:0] w;
    int bc, rs, rl, lc, lp;
    bit fz, rz, to;

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_checks++;
        if ({sdata, sclk, slatch, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=0000", {sdata, sclk, slatch, busy});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_single_digit();
        set_segs(7'h3F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        run_frame(0, 0, 0, 0, w, bc, rs, rl, lc, lp, fz, rz, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL single_timeout"); end
        n_checks++;
        if (w !== 48'h3F00_0000_0000) begin n_fail++; $display("FAIL single_word got=%h want=3f0000000000", w); end
        n_checks++;
        if (bc !== 195) begin n_fail++; $display("FAIL single_busy got=%0d want=195", bc); end
        n_checks++;
        if (lc !== 2) begin n_fail++; $display("FAIL single_latch_width got=%0d want=2", lc); end
        n_checks++;
        if (lp !== 1) begin n_fail++; $display("FAIL single_latch_pulses got=%0d want=1", lp); end
    endtask

    task automatic test_all_segments();
        set_segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`ifdef SERIAL_DP_EN
        dp = 6'b000000;
`endif
        run_frame(0, 0, 0, 0, w, bc, rs, rl, lc, lp, fz, rz, to);
        n_checks++;
        if (w !== 48'h7F7F_7F7F_7F7F) begin n_fail++; $display("FAIL all_word got=%h want=7f7f7f7f7f7f", w); end
        n_checks++;
        if (rl !== 48) begin n_fail++; $display("FAIL all_rises_before_latch got=%0d want=48", rl); end
        n_checks++;
        if (rs !== 48) begin n_fail++; $display("FAIL all_total_rises got=%0d want=48", rs); end
    endtask

    task automatic test_restart_ignored();
        set_segs(7'h12, 7'h34, 7'h56, 7'h78, 7'h1A, 7'h2B);
        run_frame(50, 0, 0, 0, w, bc, rs, rl, lc, lp, fz, rz, to);
        n_checks++;
        if (w !== 48'h1234_5678_1A2B) begin n_fail++; $display("FAIL restart_word got=%h want=123456781a2b", w); end
        n_checks++;
        if (lp !== 1) begin n_fail++; $display("FAIL restart_latch_pulses got=%0d want=1", lp); end
        n_checks++;
        if (bc !== 195) begin n_fail++; $display("FAIL restart_busy got=%0d want=195", bc); end
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_queued busy=%b want=0", busy); end
    endtask

    task automatic test_enable_freeze();
        set_segs(7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20);
        run_frame(0, 60, 20, 0, w, bc, rs, rl, lc, lp, fz, rz, to);
        n_checks++;
        if (fz !== 1'b1) begin n_fail++; $display("FAIL freeze_outputs got=%b want=1", fz); end
        n_checks++;
        if (w !== 48'h0102_0408_1020) begin n_fail++; $display("FAIL freeze_word got=%h want=010204081020", w); end
        n_checks++;
        if (bc !== 215) begin n_fail++; $display("FAIL freeze_duration got=%0d want=215", bc); end
    endtask

    task automatic test_reset_midframe();
        set_segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        run_frame(0, 0, 0, 100, w, bc, rs, rl, lc, lp, fz, rz, to);
        n_checks++;
        if (rz !== 1'b1) begin n_fail++; $display("FAIL midreset_outputs got=%b want=1", rz); end
        repeat (20) @(negedge clk);
        n_checks++;
        if ({busy, slatch} !== 2'b00) begin n_fail++; $display("FAIL midreset_idle got=%b want=00", {busy, slatch}); end
        set_segs(7'h55, 7'h2A, 7'h6B, 7'h14, 7'h0F, 7'h70);
        run_frame(0, 0, 0, 0, w, bc, rs, rl, lc, lp, fz, rz, to);
        n_checks++;
        if (w !== 48'h552A_6B14_0F70) begin n_fail++; $display("FAIL midreset_next_word got=%h want=552a6b140f70", w); end
        n_checks++;
        if (bc !== 195) begin n_fail++; $display("FAIL midreset_next_busy got=%0d want=195", bc); end
    endtask

    task automatic test_clkdiv1();
`ifdef SERIAL_DP_EN
        set_segs(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        dp = 6'b000100;
        run_frame(0, 0, 0, 0, w, bc, rs, rl, lc, lp, fz, rz, to);
        n_checks++;
        if (word1 !== 48'h0000_0080_0000) begin n_fail++; $display("FAIL div1_dp_word got=%h want=000000800000", word1); end
        dp = 6'b000000;
`else
        set_segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        run_frame(0, 0, 0, 0, w, bc, rs, rl, lc, lp, fz, rz, to);
        n_checks++;
        if (word1 !== 48'h7F7F_7F7F_7F7F) begin n_fail++; $display("FAIL div1_word got=%h want=7f7f7f7f7f7f", word1); end
`endif
        n_checks++;
        if (busy1_cnt !== 98) begin n_fail++; $display("FAIL div1_busy got=%0d want=98", busy1_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_all_segments();
        test_restart_ignored();
        test_enable_freeze();
        test_reset_midframe();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
